// File: rtl/gpu_pkg.sv
// Shared core constants: pipeline state encodings, special register indices, sequencer states.
// Latency: none (declarations only).
// Backpressure: not applicable.
package gpu_pkg;

  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;

  localparam logic [3:0] R_BLOCK_ID     = 4'd13;
  localparam logic [3:0] R_BLOCK_DIM    = 4'd14;
  localparam logic [3:0] R_THREAD_ID    = 4'd15;
  localparam logic [3:0] R_WRITABLE_MAX = 4'd12;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_READ  = 2'd1,
    SEQ_WRITE = 2'd2,
    SEQ_DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/next_active_thread.sv
// Priority finder: lowest set mask bit at or above index 'from'.
// Latency: combinational.
// Backpressure: not applicable.
module next_active_thread #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] mask,
  input  logic [W:0]   from,
  output logic [N-1:0] one_hot,
  output logic         valid
);

  // Scan downward so the lowest qualifying bit is the last one written.
  always_comb begin
    one_hot = '0;
    valid   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        one_hot    = '0;
        one_hot[i] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_port_sequencer.sv
// Time-multiplexes one shared register array across active threads (REQUEST reads, UPDATE writes).
// Latency: N active threads -> phase_done after N+1 cycles (1 when N=0); REGFILE_PARALLEL_READ_EN reads all in one cycle.
// Backpressure: none; core holds core_state and per-thread inputs stable until phase_done, any change aborts.
module regfile_port_sequencer
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int DATA_BITS         = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [2:0]                             core_state,
  input  logic [THREADS_PER_BLOCK-1:0]           thread_mask,
  input  logic [7:0]                             block_id,
  input  logic [THREADS_PER_BLOCK*4-1:0]         rs_addr,
  input  logic [THREADS_PER_BLOCK*4-1:0]         rt_addr,
  input  logic [THREADS_PER_BLOCK*4-1:0]         rd_addr,
  input  logic [THREADS_PER_BLOCK-1:0]           wr_en,
  input  logic [THREADS_PER_BLOCK*DATA_BITS-1:0] wr_data,
  output logic [THREADS_PER_BLOCK*DATA_BITS-1:0] rs_data,
  output logic [THREADS_PER_BLOCK*DATA_BITS-1:0] rt_data,
  output logic                                   phase_done,
  output logic                                   busy
);

  localparam int T    = THREADS_PER_BLOCK;
  localparam int D    = DATA_BITS;
  localparam int PW   = (T > 1) ? $clog2(T) : 1;
  localparam int NREG = int'(R_WRITABLE_MAX) + 1;

  seq_state_t state, state_nxt;
  logic [PW-1:0] ptr, ptr_nxt;
  logic          ptr_en;
  logic [2:0]    phase_state;
  logic          do_read, do_write;
  logic [PW:0]   search_from;
  logic [T-1:0]  nxt_one_hot;
  logic          nxt_vld;

  logic [T-1:0][NREG-1:0][D-1:0] mem;

  // Value seen by thread t when reading register a: stored entry or a generated constant.
  function automatic logic [D-1:0] reg_value(input logic [NREG-1:0][D-1:0] row,
                                             input logic [3:0] a, input int t,
                                             input logic [7:0] bid);
    logic [D-1:0] v;
    v = '0;
    for (int r = 0; r < NREG; r++) begin
      if (a == 4'(r)) v = row[r];
    end
    if (a == R_BLOCK_ID)  v = D'(bid);
    if (a == R_BLOCK_DIM) v = D'(T);
    if (a == R_THREAD_ID) v = D'(t);
    return v;
  endfunction

  assign search_from = (state == SEQ_IDLE) ? '0 : ({1'b0, ptr} + {{PW{1'b0}}, 1'b1});

  next_active_thread #(.N(T), .W(PW)) u_next (
    .mask    (thread_mask),
    .from    (search_from),
    .one_hot (nxt_one_hot),
    .valid   (nxt_vld)
  );

  // Encode the finder's one-hot result into a thread index.
  always_comb begin
    ptr_nxt = '0;
    for (int t = 0; t < T; t++) begin
      if (nxt_one_hot[t]) ptr_nxt = PW'(t);
    end
  end

  // Next-state, service strobes and status outputs.
  always_comb begin
    state_nxt  = state;
    ptr_en     = 1'b0;
    do_read    = 1'b0;
    do_write   = 1'b0;
    phase_done = (state == SEQ_DONE);
    busy       = (state == SEQ_READ) || (state == SEQ_WRITE);
    unique case (state)
      SEQ_IDLE: begin
        if ((core_state == CORE_REQUEST) || (core_state == CORE_UPDATE)) begin
          if (!nxt_vld) begin
            state_nxt = SEQ_DONE;
          end else begin
            state_nxt = (core_state == CORE_REQUEST) ? SEQ_READ : SEQ_WRITE;
            ptr_en    = 1'b1;
          end
        end
      end
      SEQ_READ: begin
        if (core_state != phase_state) begin
          state_nxt = SEQ_IDLE;
        end else begin
          do_read = 1'b1;
`ifdef REGFILE_PARALLEL_READ_EN
          state_nxt = SEQ_DONE;
`else
          ptr_en = nxt_vld;
          if (!nxt_vld) state_nxt = SEQ_DONE;
`endif
        end
      end
      SEQ_WRITE: begin
        if (core_state != phase_state) begin
          state_nxt = SEQ_IDLE;
        end else begin
          do_write = 1'b1;
          ptr_en   = nxt_vld;
          if (!nxt_vld) state_nxt = SEQ_DONE;
        end
      end
      SEQ_DONE: begin
        if (core_state != phase_state) state_nxt = SEQ_IDLE;
      end
      default: state_nxt = SEQ_IDLE;
    endcase
  end

  // State, service pointer and the core_state that opened the current phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SEQ_IDLE;
      ptr         <= '0;
      phase_state <= '0;
    end else begin
      state <= state_nxt;
      if (ptr_en) ptr <= ptr_nxt;
      if (state == SEQ_IDLE) phase_state <= core_state;
    end
  end

  // Operand capture: the serviced thread (or all active threads in parallel mode) updates its slices.
  always_ff @(posedge clk) begin
    if (reset) begin
      rs_data <= '0;
      rt_data <= '0;
    end else if (do_read) begin
      for (int t = 0; t < T; t++) begin
`ifdef REGFILE_PARALLEL_READ_EN
        if (thread_mask[t]) begin
`else
        if (t == int'(ptr)) begin
`endif
          rs_data[t*D +: D] <= reg_value(mem[t], rs_addr[t*4 +: 4], t, block_id);
          rt_data[t*D +: D] <= reg_value(mem[t], rt_addr[t*4 +: 4], t, block_id);
        end
      end
    end
  end

  // Writeback of the serviced thread; destinations above R12 are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem <= '0;
    end else if (do_write) begin
      for (int t = 0; t < T; t++) begin
        for (int r = 0; r < NREG; r++) begin
          if ((t == int'(ptr)) && wr_en[t] && (rd_addr[t*4 +: 4] == 4'(r))) begin
            mem[t][r] <= wr_data[t*D +: D];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Self-checking bench for regfile_port_sequencer against an array-based register model.
// Latency: checks phase_done timing per phase.
// Backpressure: not applicable.
module tb_regfile_port_sequencer;

  localparam logic [2:0] REQ = 3'b011;
  localparam logic [2:0] UPD = 3'b110;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  core_state;
  logic [3:0]  thread_mask;
  logic [7:0]  block_id;
  logic [15:0] rs_addr, rt_addr, rd_addr;
  logic [3:0]  wr_en;
  logic [31:0] wr_data;
  logic [31:0] rs_data, rt_data;
  logic        phase_done, busy;

  logic [3:0] rs_a [4];
  logic [3:0] rt_a [4];
  logic [3:0] rd_a [4];
  logic [7:0] wd   [4];

  logic [7:0] mdl  [4][13];
  logic [7:0] rs_m [4];
  logic [7:0] rt_m [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_port_sequencer #(.THREADS_PER_BLOCK(4), .DATA_BITS(8)) dut (
    .clk(clk), .reset(reset), .core_state(core_state), .thread_mask(thread_mask),
    .block_id(block_id), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .wr_en(wr_en), .wr_data(wr_data), .rs_data(rs_data), .rt_data(rt_data),
    .phase_done(phase_done), .busy(busy)
  );

  always_comb begin
    rs_addr = '0; rt_addr = '0; rd_addr = '0; wr_data = '0;
    for (int t = 0; t < 4; t++) begin
      rs_addr[t*4 +: 4] = rs_a[t];
      rt_addr[t*4 +: 4] = rt_a[t];
      rd_addr[t*4 +: 4] = rd_a[t];
      wr_data[t*8 +: 8] = wd[t];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Architectural value of register a as seen by thread t.
  function automatic logic [7:0] mval(input int t, input logic [3:0] a);
    if (a == 4'd13) return block_id;
    if (a == 4'd14) return 8'd4;
    if (a == 4'd15) return 8'(t);
    return mdl[t][a];
  endfunction

  task automatic model_clear();
    for (int t = 0; t < 4; t++) begin
      rs_m[t] = '0; rt_m[t] = '0;
      for (int r = 0; r < 13; r++) mdl[t][r] = '0;
    end
  endtask

  task automatic model_write(input int t);
    if (wr_en[t] && rd_a[t] < 4'd13) mdl[t][rd_a[t]] = wd[t];
  endtask

  task automatic check_outputs(input string tag);
    for (int t = 0; t < 4; t++) begin
      check($sformatf("%s_rs%0d", tag, t), 32'(rs_data[t*8 +: 8]), 32'(rs_m[t]));
      check($sformatf("%s_rt%0d", tag, t), 32'(rt_data[t*8 +: 8]), 32'(rt_m[t]));
    end
  endtask

  // Full phase: model update, latency, hold in DONE, release to IDLE, operand check.
  task automatic run_phase(input logic [2:0] cs, input string tag);
    int n, cyc, exp_cyc;
    n = $countones(thread_mask);
    exp_cyc = n + 1;
`ifdef REGFILE_PARALLEL_READ_EN
    if (cs == REQ && n > 0) exp_cyc = 2;
`endif
    for (int t = 0; t < 4; t++) begin
      if (thread_mask[t]) begin
        if (cs == REQ) begin
          rs_m[t] = mval(t, rs_a[t]);
          rt_m[t] = mval(t, rt_a[t]);
        end else begin
          model_write(t);
        end
      end
    end
    core_state = cs;
    cyc = 0;
    while (!phase_done && cyc < 40) begin
      step();
      cyc++;
      if (cyc == 1 && n > 0) check({tag, "_busy"}, 32'(busy), 32'd1);
    end
    check({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
    step();
    check({tag, "_done_hold"}, 32'(phase_done), 32'd1);
    core_state = 3'b000;
    step();
    check({tag, "_done_clr"}, 32'(phase_done), 32'd0);
    check_outputs(tag);
  endtask

  initial begin
    reset = 1'b1; core_state = '0; thread_mask = '0; block_id = '0; wr_en = '0;
    for (int t = 0; t < 4; t++) begin
      rs_a[t] = '0; rt_a[t] = '0; rd_a[t] = '0; wd[t] = '0;
    end
    model_clear();
    step(); step();
    reset = 1'b0;
    step();
    check("rst_done", 32'(phase_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check_outputs("rst");

    // All threads read R14/R15.
    thread_mask = 4'b1111;
    for (int t = 0; t < 4; t++) begin rs_a[t] = 4'd14; rt_a[t] = 4'd15; end
    run_phase(REQ, "dim_tid");

    // Sparse writes then read back.
    thread_mask = 4'b1010;
    wr_en = 4'b1010;
    rd_a[1] = 4'd3;  wd[1] = 8'h5A;
    rd_a[3] = 4'd12; wd[3] = 8'hFF;
    run_phase(UPD, "wr_sparse");
    rs_a[1] = 4'd3; rt_a[1] = 4'd0; rs_a[3] = 4'd12; rt_a[3] = 4'd12;
    run_phase(REQ, "rd_sparse");
    check("rd_5a", 32'(rs_data[15:8]), 32'h5A);
    check("rd_ff", 32'(rs_data[31:24]), 32'hFF);

    // Write to R13 is dropped; R13 reads block_id.
    thread_mask = 4'b0001; wr_en = 4'b0001; rd_a[0] = 4'd13; wd[0] = 8'h77;
    block_id = 8'h09;
    run_phase(UPD, "wr_r13");
    rs_a[0] = 4'd13; rt_a[0] = 4'd12;
    run_phase(REQ, "rd_r13");
    check("r13_val", 32'(rs_data[7:0]), 32'h09);

    // Empty mask.
    thread_mask = 4'b0000;
    run_phase(REQ, "empty");

    // Abort after two of four writes.
    thread_mask = 4'b1111; wr_en = 4'b1111;
    for (int t = 0; t < 4; t++) begin rd_a[t] = 4'(t + 1); wd[t] = 8'hA0 + 8'(t); end
    core_state = UPD;
    step(); step(); step();
    check("abort_busy", 32'(busy), 32'd1);
    check("abort_done_pre", 32'(phase_done), 32'd0);
    core_state = 3'b000;
    step();
    check("abort_busy_clr", 32'(busy), 32'd0);
    check("abort_done", 32'(phase_done), 32'd0);
    model_write(0); model_write(1);
    step();
    check("abort_idle_done", 32'(phase_done), 32'd0);
    for (int t = 0; t < 4; t++) begin rs_a[t] = rd_a[t]; rt_a[t] = 4'(t); end
    run_phase(REQ, "abort_rd");

    // Reset in the middle of a write phase.
    for (int t = 0; t < 4; t++) wd[t] = 8'h3C + 8'(t);
    core_state = UPD;
    step(); step();
    reset = 1'b1; core_state = 3'b000;
    step();
    reset = 1'b0;
    model_clear();
    check("midrst_done", 32'(phase_done), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check_outputs("midrst");
    step();
    for (int t = 0; t < 4; t++) begin rs_a[t] = rd_a[t]; rt_a[t] = 4'(t); end
    run_phase(REQ, "midrst_rd");

    // Randomized phases.
    for (int i = 0; i < 24; i++) begin
      thread_mask = 4'($urandom_range(0, 15));
      wr_en       = 4'($urandom_range(0, 15));
      block_id    = 8'($urandom);
      for (int t = 0; t < 4; t++) begin
        rs_a[t] = 4'($urandom_range(0, 15));
        rt_a[t] = 4'($urandom_range(0, 15));
        rd_a[t] = 4'($urandom_range(0, 15));
        wd[t]   = 8'($urandom);
      end
      run_phase((i % 2 == 0) ? UPD : REQ, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
